// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer: default sizing, CDB channel
// numbering and the default-width entry layout.
package rob_pkg;

  localparam int ROB_DEPTH   = 8;
  localparam int ROB_DATA_W  = 32;
  localparam int ROB_DEST_W  = 5;
  localparam int ROB_NUM_CDB = 6;

  localparam int CDB_ADD1  = 0;
  localparam int CDB_ADD2  = 1;
  localparam int CDB_ADD3  = 2;
  localparam int CDB_MULT1 = 3;
  localparam int CDB_MULT2 = 4;
  localparam int CDB_LS    = 5;

  // Entry layout at the default widths; the parametrised top keeps the same
  // fields as separate arrays so DATA_W/DEST_W can be overridden.
  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic [ROB_DEST_W-1:0] dest;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_cdb_match.sv
// Per-entry CDB snoop: flags any valid channel carrying this entry's tag and
// selects the data of the lowest-numbered matching channel.
module rob_cdb_match
  import rob_pkg::*;
#(
  parameter int IDX_W   = $clog2(ROB_DEPTH),
  parameter int DATA_W  = ROB_DATA_W,
  parameter int NUM_CDB = ROB_NUM_CDB,
  parameter int ENTRY   = 0
) (
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*IDX_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  output logic                      hit,
  output logic [DATA_W-1:0]         hit_data
);

  localparam logic [IDX_W-1:0] MY_TAG = IDX_W'(ENTRY);

  // Scan high to low so the lowest matching channel is the last one written.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = NUM_CDB - 1; i >= 0; i--) begin
      if (cdb_valid[i] && (cdb_tag[i*IDX_W +: IDX_W] == MY_TAG)) begin
        hit      = 1'b1;
        hit_data = cdb_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/rob_param.sv
// Circular reorder buffer: in-order allocate, tag-addressed CDB writeback,
// in-order valid/ready commit, synchronous flush.
module rob_param
  import rob_pkg::*;
#(
  parameter  int DEPTH   = ROB_DEPTH,
  parameter  int DATA_W  = ROB_DATA_W,
  parameter  int DEST_W  = ROB_DEST_W,
  parameter  int NUM_CDB = ROB_NUM_CDB,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      alloc_valid,
  output logic                      alloc_ready,
  input  logic [DEST_W-1:0]         alloc_dest,
  output logic [IDX_W-1:0]          alloc_tag,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*IDX_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  output logic                      commit_valid,
  input  logic                      commit_ready,
  output logic [IDX_W-1:0]          commit_tag,
  output logic [DEST_W-1:0]         commit_dest,
  output logic [DATA_W-1:0]         commit_data,
  output logic [IDX_W:0]            count,
  output logic                      full,
  output logic                      empty
);

  localparam logic [IDX_W:0] PTR_ONE = (IDX_W+1)'(1);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [IDX_W:0]     head_q, tail_q, count_q;
  logic [DEPTH-1:0]   busy_q, done_q;
  logic [DEST_W-1:0]  dest_q [DEPTH];
  logic [DATA_W-1:0]  data_q [DEPTH];

  logic [DEPTH-1:0]   cdb_hit;
  logic [DATA_W-1:0]  cdb_hit_data [DEPTH];

  logic [IDX_W-1:0]   head_idx, tail_idx;
  logic               alloc_fire, commit_fire, cdb_dup;

  for (genvar e = 0; e < DEPTH; e++) begin : g_match
    rob_cdb_match #(
      .IDX_W   (IDX_W),
      .DATA_W  (DATA_W),
      .NUM_CDB (NUM_CDB),
      .ENTRY   (e)
    ) u_match (
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .hit       (cdb_hit[e]),
      .hit_data  (cdb_hit_data[e])
    );
  end

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  assign full  = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign empty = (head_q == tail_q);

  // Full blocks allocation even if the head retires this cycle; flush
  // swallows any handshake and hides the head entry.
  assign alloc_ready  = !full;
  assign alloc_tag    = tail_idx;
  assign alloc_fire   = alloc_valid && alloc_ready && !flush;

  assign commit_valid = busy_q[head_idx] && done_q[head_idx] && !flush;
  assign commit_fire  = commit_valid && commit_ready;
  assign commit_tag   = head_idx;
  assign commit_dest  = dest_q[head_idx];
  assign commit_data  = data_q[head_idx];
  assign count        = count_q;

  // Pointer, occupancy and per-entry state update; flush outranks everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        dest_q[e] <= '0;
        data_q[e] <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      done_q  <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (alloc_fire && (tail_idx == IDX_W'(e))) begin
          busy_q[e] <= 1'b1;
          done_q[e] <= 1'b0;
          dest_q[e] <= alloc_dest;
          data_q[e] <= '0;
        end else begin
          if (cdb_hit[e] && busy_q[e] && !done_q[e]) begin
            done_q[e] <= 1'b1;
            data_q[e] <= cdb_hit_data[e];
          end
          if (commit_fire && (head_idx == IDX_W'(e))) begin
            busy_q[e] <= 1'b0;
          end
        end
      end
      if (alloc_fire)  tail_q <= tail_q + PTR_ONE;
      if (commit_fire) head_q <= head_q + PTR_ONE;
      count_q <= count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);
    end
  end

  // Detect two valid channels carrying the same tag in one cycle.
  always_comb begin
    cdb_dup = 1'b0;
    for (int i = 0; i < NUM_CDB; i++) begin
      for (int j = i + 1; j < NUM_CDB; j++) begin
        if (cdb_valid[i] && cdb_valid[j] &&
            (cdb_tag[i*IDX_W +: IDX_W] == cdb_tag[j*IDX_W +: IDX_W])) begin
          cdb_dup = 1'b1;
        end
      end
    end
  end

  a_cdb_unique_tag: assert property (@(posedge clk) disable iff (rst) !cdb_dup)
    else $error("rob_param: two CDB channels broadcast to the same tag");

endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param at default sizing: fill, out-of-order
// completion, wrap-around, backpressure, flush and asynchronous reset.
module tb_rob_param;
  import rob_pkg::*;

  localparam int IDX_W = 3;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         alloc_valid;
  logic         alloc_ready;
  logic [4:0]   alloc_dest;
  logic [2:0]   alloc_tag;
  logic [5:0]   cdb_valid;
  logic [17:0]  cdb_tag;
  logic [191:0] cdb_data;
  logic         commit_valid;
  logic         commit_ready;
  logic [2:0]   commit_tag;
  logic [4:0]   commit_dest;
  logic [31:0]  commit_data;
  logic [3:0]   count;
  logic         full;
  logic         empty;

  int n_checks = 0;
  int n_err    = 0;

  rob_param dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .alloc_valid  (alloc_valid),
    .alloc_ready  (alloc_ready),
    .alloc_dest   (alloc_dest),
    .alloc_tag    (alloc_tag),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .commit_tag   (commit_tag),
    .commit_dest  (commit_dest),
    .commit_data  (commit_data),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cdb_drive(input int ch, input int tag, input logic [31:0] d);
    cdb_valid[ch]               = 1'b1;
    cdb_tag[ch*IDX_W +: IDX_W]  = 3'(tag);
    cdb_data[ch*32 +: 32]       = d;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_alloc_ready"},  alloc_ready,  1);
    chk({pfx, "_alloc_tag"},    alloc_tag,    0);
    chk({pfx, "_commit_valid"}, commit_valid, 0);
    chk({pfx, "_commit_tag"},   commit_tag,   0);
    chk({pfx, "_commit_dest"},  commit_dest,  0);
    chk({pfx, "_commit_data"},  commit_data,  0);
    chk({pfx, "_count"},        count,        0);
    chk({pfx, "_full"},         full,         0);
    chk({pfx, "_empty"},        empty,        1);
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    alloc_valid  = 1'b0;
    alloc_dest   = '0;
    cdb_valid    = '0;
    cdb_tag      = '0;
    cdb_data     = '0;
    commit_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outputs("reset");

    // Fill: tags 0..7, dest 1..8, no completions.
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = 5'(i + 1);
      #1;
      chk("fill_ready", alloc_ready, 1);
      chk("fill_tag", alloc_tag, i);
      chk("fill_commit_valid", commit_valid, 0);
      step();
    end
    #1;
    chk("full_flag", full, 1);
    chk("full_ready", alloc_ready, 0);
    chk("full_count", count, 8);
    step();
    chk("ninth_alloc_count", count, 8);
    chk("ninth_alloc_ready", alloc_ready, 0);
    chk("ninth_commit_valid", commit_valid, 0);
    alloc_valid = 1'b0;

    // Out-of-order completion, in-order commit.
    commit_ready = 1'b1;
    cdb_drive(CDB_MULT1, 2, 32'h30);
    step();
    cdb_valid = '0;
    chk("ooo_head_not_done", commit_valid, 0);
    cdb_drive(CDB_ADD1, 0, 32'h10);
    step();
    cdb_valid = '0;
    chk("ooo_c0_valid", commit_valid, 1);
    chk("ooo_c0_tag", commit_tag, 0);
    chk("ooo_c0_data", commit_data, 32'h10);
    chk("ooo_c0_dest", commit_dest, 1);
    cdb_drive(CDB_LS, 1, 32'h20);
    step();
    cdb_valid = '0;
    chk("ooo_c1_valid", commit_valid, 1);
    chk("ooo_c1_tag", commit_tag, 1);
    chk("ooo_c1_data", commit_data, 32'h20);
    chk("ooo_c1_dest", commit_dest, 2);
    step();
    chk("ooo_c2_valid", commit_valid, 1);
    chk("ooo_c2_tag", commit_tag, 2);
    chk("ooo_c2_data", commit_data, 32'h30);
    chk("ooo_c2_dest", commit_dest, 3);
    step();
    chk("ooo_after_valid", commit_valid, 0);
    chk("ooo_after_tag", commit_tag, 3);
    chk("ooo_after_count", count, 5);

    // Drain tags 3..7 back to empty.
    for (int t = 3; t < 8; t++) begin
      cdb_drive(CDB_ADD2, t, 32'h100 + 32'(t));
      step();
      cdb_valid = '0;
      chk("drain_valid", commit_valid, 1);
      chk("drain_tag", commit_tag, t);
      chk("drain_data", commit_data, 32'h100 + 32'(t));
      chk("drain_dest", commit_dest, t + 1);
    end
    step();
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
    chk("drain_alloc_tag", alloc_tag, 0);
    chk("drain_commit_valid", commit_valid, 0);

    // Wrap-around with a single entry in flight.
    for (int k = 0; k < 20; k++) begin
      alloc_valid = 1'b1;
      alloc_dest  = 5'((k % 31) + 1);
      #1;
      chk("wrap_alloc_tag", alloc_tag, k % 8);
      step();
      alloc_valid = 1'b0;
      chk("wrap_count_one", count, 1);
      cdb_drive(k % 6, k % 8, 32'h1000 + 32'(k));
      step();
      cdb_valid = '0;
      chk("wrap_commit_valid", commit_valid, 1);
      chk("wrap_commit_tag", commit_tag, k % 8);
      chk("wrap_commit_data", commit_data, 32'h1000 + 32'(k));
      chk("wrap_commit_dest", commit_dest, (k % 31) + 1);
      step();
      chk("wrap_count_zero", count, 0);
    end

    // Backpressure on the commit port.
    commit_ready = 1'b0;
    alloc_valid  = 1'b1;
    alloc_dest   = 5'd9;
    #1;
    chk("bp_alloc_tag", alloc_tag, 4);
    step();
    alloc_valid = 1'b0;
    cdb_drive(CDB_MULT2, 4, 32'hABCD);
    step();
    cdb_valid = '0;
    repeat (5) begin
      chk("bp_hold_valid", commit_valid, 1);
      chk("bp_hold_tag", commit_tag, 4);
      chk("bp_hold_dest", commit_dest, 9);
      chk("bp_hold_data", commit_data, 32'hABCD);
      chk("bp_hold_count", count, 1);
      step();
    end
    commit_ready = 1'b1;
    #1;
    chk("bp_release_valid", commit_valid, 1);
    step();
    chk("bp_after_count", count, 0);
    chk("bp_after_valid", commit_valid, 0);
    chk("bp_after_tag", commit_tag, 5);

    // Flush with 5 outstanding, 2 done, and an allocation in the flush cycle.
    commit_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = 5'(10 + i);
      #1;
      chk("fl_alloc_tag", alloc_tag, (5 + i) % 8);
      step();
    end
    alloc_valid = 1'b0;
    cdb_drive(CDB_ADD1, 5, 32'h55);
    cdb_drive(CDB_ADD3, 6, 32'h66);
    step();
    cdb_valid = '0;
    chk("fl_pre_valid", commit_valid, 1);
    chk("fl_pre_tag", commit_tag, 5);
    chk("fl_pre_data", commit_data, 32'h55);
    chk("fl_pre_count", count, 5);
    flush        = 1'b1;
    alloc_valid  = 1'b1;
    alloc_dest   = 5'd20;
    commit_ready = 1'b1;
    #1;
    chk("fl_forced_valid", commit_valid, 0);
    step();
    flush       = 1'b0;
    alloc_valid = 1'b0;
    chk("fl_empty", empty, 1);
    chk("fl_count", count, 0);
    chk("fl_alloc_tag0", alloc_tag, 0);
    chk("fl_commit_valid", commit_valid, 0);
    chk("fl_commit_tag", commit_tag, 0);
    cdb_drive(CDB_ADD1, 0, 32'hDEAD);
    cdb_drive(CDB_ADD2, 3, 32'hBEEF);
    step();
    cdb_valid = '0;
    chk("stale_commit_valid", commit_valid, 0);
    chk("stale_count", count, 0);
    chk("stale_empty", empty, 1);

    // Asynchronous reset between edges with 4 entries outstanding.
    commit_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = 5'(1 + i);
      step();
    end
    alloc_valid = 1'b0;
    cdb_drive(CDB_LS, 0, 32'h77);
    step();
    cdb_valid = '0;
    chk("ar_pre_count", count, 4);
    chk("ar_pre_valid", commit_valid, 1);
    chk("ar_pre_data", commit_data, 32'h77);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ar_release_count", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
